control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired sequencer that drives every ALUSystem control input, replacing the vector file that test benches apply today.
- Fetches a 16-bit instruction from memory as two bytes into IR, decodes it, and issues one to three execute micro-cycles.
- Latches the Z flag for conditional branches.
- Sits beside ALUSystem inside CompleteSystem. IROut and ALUOutFlag are fed back into it.

Parameters:
NOP_OPCODE, 4'hB, opcode treated as an explicit no-op (2-cycle fetch, 1 idle execute cycle)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
IROut  input  16  instruction register contents
ALUOutFlag  input  4  {Z,C,N,O} from ALU
RF_OutASel, RF_OutBSel, RF_FunSel  output  2 each  register file controls
RF_RegSel  output  4  active-low; bit(3-n) enables Rn
ALU_FunSel  output  4  ALU function
ARF_OutCSel, ARF_OutDSel, ARF_FunSel  output  2 each  ARF controls; OutDSel 00=AR, 01=SP, 10=PC
ARF_RegSel  output  3  active-low; 011=PC, 101=AR, 110=SP
IR_LH, IR_Enable  output  1 each  IR byte select (0=low), IR enable
IR_Funsel  output  2  IR function
Mem_WR, Mem_CS  output  1 each  Mem_WR 1=write; Mem_CS active-low
MuxASel, MuxBSel  output  2 each  00=ALUOut, 01=MemoryOut, 10=IROut[7:0], 11=ARF_COut
MuxCSel  output  1  ALU A source: 0=RF AOut, 1=ARF COut
SeqT  output  3  current T-state
Halted  output  1  high after HLT

Behaviour:
Encodings:
- Register FunSel: 00 = dec, 01 = inc, 10 = load, 11 = clear. Applies to RF, ARF and IR.
- ALU_FunSel: 0000 = pass A, 0100 = A+B, 0101 = A-B, 0111 = AND, 1000 = OR.

Idle vector (driven whenever a field is not named below):
- RegSels = all 1s, IR_Enable = 0, Mem_CS = 1, Mem_WR = 0.
- All other fields = 0.

Reset:
- Asserting Reset (low) forces the idle vector and INIT immediately, even mid-instruction.
- Also clears z_flag, Halted, and SeqT=0.

States:
- INIT (1 cycle after release): ARF_FunSel=11, ARF_RegSel=011 (clear PC).
- T0: OutDSel=10, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=10. Same cycle: PC inc (ARF_FunSel=01, RegSel=011).
- T1: as T0 with IR_LH=1.
- T2..T4: execute. After the last execute cycle, go to T0.

Instruction fields: IR[15:12] = op, [11:10] = Rd, [9:8] = Rs, [7:0] = imm/addr.

Execute micro-ops:
- 0..3 ADD/SUB/AND/OR (T2 only): OutASel=Rd, OutBSel=Rs, MuxCSel=0, ALU_FunSel per table, MuxASel=00, RF load Rd. z_flag <= ALUOutFlag[3] at end of T2.
- 4 LDI (T2): MuxASel=10, RF load Rd.
- 5 LD: T2: MuxBSel=10, ARF load AR. T3: OutDSel=00, Mem_CS=0, MuxASel=01, RF load Rd.
- 6 ST: T2: load AR. T3: OutASel=Rd, ALU pass A, OutDSel=00, Mem_CS=0, Mem_WR=1.
- 7 BRA (T2): MuxBSel=10, ARF load PC.
- 8 BEQ (T2): same as BRA only if z_flag=1; otherwise idle vector.
- 9 INC / A DEC (T2): RF_FunSel 01/00 on Rd. z_flag unchanged.
- F HLT (T2): set Halted, enter HALT.
- HALT: idle vector forever until Reset.
- NOP_OPCODE and all undefined opcodes: one idle T2.

Timing and boundaries:
- Latency: 3 cycles for single-cycle ops, 4 for LD/ST.
- PC wraps 0xFF -> 0x00 (ARF behaviour). Fetch is unaffected.
- Fetched IR is used only from T2 onward. Decode uses IROut combinationally during T2..T4.
- Outputs are pure functions of state, IROut and z_flag (Moore plus decode), with no glitch requirement.
- Exactly one of RF_RegSel / ARF_RegSel / IR_Enable / Mem write is active per cycle, except T0/T1 (IR load plus PC inc).

Test Plan:
1. Release Reset with memory[0..1] = {0x0A,0x45} (LDI R1,0x0A; IR = 0x450A) -> INIT, T0, T1, T2; R1=0x0A after T2; PC=2; SeqT returns to 0.
2. LDI R0,5; LDI R1,5; SUB R0,R1 (0x1100); BEQ 0x20 (0x8020) -> R0=0, z_flag=1, PC=0x20 after BEQ T2.
3. Same as 2 with R1=4 -> z_flag=0, BEQ idle, PC continues at 8.
4. LDI R2,0x77; ST R2,0x40 (0x6840); LD R3,0x40 (0x5C40) -> memory[0x40]=0x77 at end of ST T3, R3=0x77, AR=0x40.
5. Pull Reset low during LD T3 -> outputs go idle asynchronously, no RF load; after release INIT clears PC and fetch restarts at 0.
6. HLT (0xF000) -> Halted=1, idle vector held for 20 cycles, PC frozen.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for ALUSystem.
// Fetches a 16-bit instruction as two bytes into IR, then issues 1..3
// execute micro-cycles. It latches the ALU Z flag for BEQ.
module control_unit #(
    parameter logic [3:0] NOP_OPCODE = 4'hB
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  SeqT,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_INIT,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_LDI = 4'h4,
        OP_LD  = 4'h5,
        OP_ST  = 4'h6,
        OP_BRA = 4'h7,
        OP_BEQ = 4'h8,
        OP_INC = 4'h9,
        OP_DEC = 4'hA,
        OP_HLT = 4'hF
    } op_e;

    // Register-file / ARF / IR function encodings
    localparam logic [1:0] FUN_DEC   = 2'b00;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    // ARF register selects (active-low)
    localparam logic [2:0] ARF_SEL_PC = 3'b011;
    localparam logic [2:0] ARF_SEL_AR = 3'b101;

    // Mux sources
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    // ARF OutD sources
    localparam logic [1:0] OUTD_AR = 2'b00;
    localparam logic [1:0] OUTD_PC = 2'b10;

    state_e     state_q, state_d;
    logic       z_flag_q, z_flag_d;
    logic       halted_q, halted_d;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       is_nop;
    logic       is_alu;
    logic [1:0] exec_len;
    logic       last_exec;
    logic [3:0] rd_regsel;

    assign op        = IROut[15:12];
    assign rd        = IROut[11:10];
    assign rs        = IROut[9:8];
    assign is_nop    = (op == NOP_OPCODE);
    assign is_alu    = !is_nop && (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
    assign rd_regsel = ~(4'b1000 >> rd);

    // Number of execute micro-cycles for the decoded instruction
    always_comb begin
        exec_len = 2'd1;
        if (!is_nop && (op == OP_LD || op == OP_ST)) begin
            exec_len = 2'd2;
        end
    end

    assign last_exec = (state_q == S_T2 && exec_len == 2'd1) ||
                       (state_q == S_T3 && exec_len == 2'd2) ||
                       (state_q == S_T4);

    // State, Z flag and halt registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_INIT;
            z_flag_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_flag_q <= z_flag_d;
            halted_q <= halted_d;
        end
    end

    // Next-state, Z flag capture and halt latch
    always_comb begin
        state_d  = state_q;
        z_flag_d = z_flag_q;
        halted_d = halted_q;
        case (state_q)
            S_INIT: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if (is_alu) begin
                    z_flag_d = ALUOutFlag[3];
                end
                if (!is_nop && op == OP_HLT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (last_exec) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3:   state_d = last_exec ? S_T0 : S_T4;
            S_T4:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    // Control vector: idle defaults, overridden per state and decoded op.
    // Held idle while Reset is low so the bus goes quiet without waiting for a clock.
    always_comb begin
        RF_OutASel  = '0;
        RF_OutBSel  = '0;
        RF_FunSel   = '0;
        RF_RegSel   = '1;
        ALU_FunSel  = '0;
        ARF_OutCSel = '0;
        ARF_OutDSel = '0;
        ARF_FunSel  = '0;
        ARF_RegSel  = '1;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = '0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = '0;
        MuxBSel     = '0;
        MuxCSel     = 1'b0;
        SeqT        = '0;
        Halted      = 1'b0;
        if (Reset) begin
            Halted = halted_q;
            case (state_q)
                S_INIT: begin
                    ARF_FunSel = FUN_CLEAR;
                    ARF_RegSel = ARF_SEL_PC;
                end
                S_T0, S_T1: begin
                    SeqT        = (state_q == S_T1) ? 3'd1 : 3'd0;
                    ARF_OutDSel = OUTD_PC;
                    Mem_CS      = 1'b0;
                    IR_Enable   = 1'b1;
                    IR_LH       = (state_q == S_T1);
                    IR_Funsel   = FUN_LOAD;
                    ARF_FunSel  = FUN_INC;
                    ARF_RegSel  = ARF_SEL_PC;
                end
                S_T2: begin
                    SeqT = 3'd2;
                    if (!is_nop) begin
                        case (op)
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                RF_OutASel = rd;
                                RF_OutBSel = rs;
                                MuxCSel    = 1'b0;
                                case (op)
                                    OP_ADD:  ALU_FunSel = 4'b0100;
                                    OP_SUB:  ALU_FunSel = 4'b0101;
                                    OP_AND:  ALU_FunSel = 4'b0111;
                                    default: ALU_FunSel = 4'b1000;
                                endcase
                                MuxASel   = MUX_ALU;
                                RF_FunSel = FUN_LOAD;
                                RF_RegSel = rd_regsel;
                            end
                            OP_LDI: begin
                                MuxASel   = MUX_IMM;
                                RF_FunSel = FUN_LOAD;
                                RF_RegSel = rd_regsel;
                            end
                            OP_LD, OP_ST: begin
                                MuxBSel    = MUX_IMM;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = ARF_SEL_AR;
                            end
                            OP_BRA: begin
                                MuxBSel    = MUX_IMM;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = ARF_SEL_PC;
                            end
                            OP_BEQ: begin
                                if (z_flag_q) begin
                                    MuxBSel    = MUX_IMM;
                                    ARF_FunSel = FUN_LOAD;
                                    ARF_RegSel = ARF_SEL_PC;
                                end
                            end
                            OP_INC: begin
                                RF_FunSel = FUN_INC;
                                RF_RegSel = rd_regsel;
                            end
                            OP_DEC: begin
                                RF_FunSel = FUN_DEC;
                                RF_RegSel = rd_regsel;
                            end
                            default: ;
                        endcase
                    end
                end
                S_T3: begin
                    SeqT = 3'd3;
                    if (!is_nop && op == OP_LD) begin
                        ARF_OutDSel = OUTD_AR;
                        Mem_CS      = 1'b0;
                        MuxASel     = MUX_MEM;
                        RF_FunSel   = FUN_LOAD;
                        RF_RegSel   = rd_regsel;
                    end else if (!is_nop && op == OP_ST) begin
                        RF_OutASel  = rd;
                        MuxCSel     = 1'b0;
                        ALU_FunSel  = 4'b0000;
                        ARF_OutDSel = OUTD_AR;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                    end
                end
                S_T4: SeqT = 3'd4;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks a hand-written instruction stream
// and compares the full control vector every cycle of interest.
module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  SeqT;
    logic        Halted;

    typedef struct packed {
        logic [1:0] oa;
        logic [1:0] ob;
        logic [1:0] rff;
        logic [3:0] rrs;
        logic [3:0] alu;
        logic [1:0] oc;
        logic [1:0] od;
        logic [1:0] aff;
        logic [2:0] ars;
        logic       lh;
        logic       ire;
        logic [1:0] irf;
        logic       wr;
        logic       cs;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic [2:0] t;
        logic       h;
    } vec_t;

    vec_t obs;
    vec_t e;
    int   checks;
    int   failures;

    control_unit #(.NOP_OPCODE(4'hB)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
        .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .SeqT(SeqT), .Halted(Halted)
    );

    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
                  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
                  IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
                  MuxASel, MuxBSel, MuxCSel, SeqT, Halted};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t idle(input logic [2:0] t, input logic h);
        vec_t v;
        v     = '0;
        v.rrs = 4'b1111;
        v.ars = 3'b111;
        v.cs  = 1'b1;
        v.t   = t;
        v.h   = h;
        return v;
    endfunction

    function automatic vec_t fetch_vec(input logic lh);
        vec_t v;
        v     = idle(lh ? 3'd1 : 3'd0, 1'b0);
        v.od  = 2'b10;
        v.cs  = 1'b0;
        v.ire = 1'b1;
        v.lh  = lh;
        v.irf = 2'b10;
        v.aff = 2'b01;
        v.ars = 3'b011;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    task automatic fetch(input string tag);
        cyc();
        check({tag, "_T0"}, fetch_vec(1'b0));
        cyc();
        check({tag, "_T1"}, fetch_vec(1'b1));
    endtask

    task automatic exec(input logic [15:0] ir, input logic [3:0] flags);
        cyc();
        IROut      = ir;
        ALUOutFlag = flags;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        Reset      = 1'b0;
        IROut      = 16'h0000;
        ALUOutFlag = 4'h0;

        #3;
        check("reset_idle", idle(3'd0, 1'b0));
        #9;
        Reset = 1'b1;
        #1;
        e = idle(3'd0, 1'b0); e.aff = 2'b11; e.ars = 3'b011;
        check("init", e);

        // LDI R1,0x0A
        fetch("ldi");
        exec(16'h450A, 4'h0);
        e = idle(3'd2, 1'b0); e.ma = 2'b10; e.rff = 2'b10; e.rrs = 4'b1011;
        check("ldi_T2", e);

        // SUB R0,R1 with Z=1
        fetch("sub1");
        exec(16'h1100, 4'b1000);
        e = idle(3'd2, 1'b0); e.oa = 2'd0; e.ob = 2'd1; e.alu = 4'b0101;
        e.rff = 2'b10; e.rrs = 4'b0111;
        check("sub1_T2", e);

        // INC R2 must not disturb z_flag
        fetch("inc");
        exec(16'h9800, 4'b0000);
        e = idle(3'd2, 1'b0); e.rff = 2'b01; e.rrs = 4'b1101;
        check("inc_T2", e);

        // BEQ taken
        fetch("beq1");
        exec(16'h8020, 4'b0000);
        e = idle(3'd2, 1'b0); e.mb = 2'b10; e.aff = 2'b10; e.ars = 3'b011;
        check("beq_taken", e);

        // SUB with Z=0, then BEQ not taken
        fetch("sub2");
        exec(16'h1100, 4'b0000);
        e = idle(3'd2, 1'b0); e.oa = 2'd0; e.ob = 2'd1; e.alu = 4'b0101;
        e.rff = 2'b10; e.rrs = 4'b0111;
        check("sub2_T2", e);
        fetch("beq2");
        exec(16'h8020, 4'b0000);
        check("beq_not_taken", idle(3'd2, 1'b0));

        // AND R3,R2 and OR R0,R1
        fetch("and");
        exec(16'h2E00, 4'b0000);
        e = idle(3'd2, 1'b0); e.oa = 2'd3; e.ob = 2'd2; e.alu = 4'b0111;
        e.rff = 2'b10; e.rrs = 4'b1110;
        check("and_T2", e);
        fetch("or");
        exec(16'h3100, 4'b0000);
        e = idle(3'd2, 1'b0); e.oa = 2'd0; e.ob = 2'd1; e.alu = 4'b1000;
        e.rff = 2'b10; e.rrs = 4'b0111;
        check("or_T2", e);

        // NOP and an undefined opcode: one idle T2 each
        fetch("nop");
        exec(16'hB000, 4'b1000);
        check("nop_T2", idle(3'd2, 1'b0));
        fetch("undef");
        exec(16'hC123, 4'b1000);
        check("undef_T2", idle(3'd2, 1'b0));

        // DEC R1
        fetch("dec");
        exec(16'hA400, 4'b0000);
        e = idle(3'd2, 1'b0); e.rff = 2'b00; e.rrs = 4'b1011;
        check("dec_T2", e);

        // ST R2,0x40
        fetch("st");
        exec(16'h6840, 4'b0000);
        e = idle(3'd2, 1'b0); e.mb = 2'b10; e.aff = 2'b10; e.ars = 3'b101;
        check("st_T2", e);
        cyc();
        e = idle(3'd3, 1'b0); e.oa = 2'd2; e.alu = 4'b0000; e.od = 2'b00;
        e.cs = 1'b0; e.wr = 1'b1;
        check("st_T3", e);

        // ADD R0,R0 with Z=1 so that reset has a set flag to clear
        fetch("add");
        exec(16'h0000, 4'b1000);
        e = idle(3'd2, 1'b0); e.alu = 4'b0100; e.rff = 2'b10; e.rrs = 4'b0111;
        check("add_T2", e);

        // LD R3,0x40, reset asserted during T3
        fetch("ld");
        exec(16'h5C40, 4'b0000);
        e = idle(3'd2, 1'b0); e.mb = 2'b10; e.aff = 2'b10; e.ars = 3'b101;
        check("ld_T2", e);
        cyc();
        e = idle(3'd3, 1'b0); e.od = 2'b00; e.cs = 1'b0; e.ma = 2'b01;
        e.rff = 2'b10; e.rrs = 4'b1110;
        check("ld_T3", e);
        #1;
        Reset = 1'b0;
        #1;
        check("ld_T3_async_reset", idle(3'd0, 1'b0));
        cyc();
        check("reset_held", idle(3'd0, 1'b0));
        Reset = 1'b1;
        #1;
        e = idle(3'd0, 1'b0); e.aff = 2'b11; e.ars = 3'b011;
        check("init_after_reset", e);

        // z_flag was cleared by reset: BEQ not taken
        fetch("beq3");
        exec(16'h8020, 4'b0000);
        check("beq_after_reset", idle(3'd2, 1'b0));

        // HLT, then idle with Halted for 20 cycles
        fetch("hlt");
        exec(16'hF000, 4'b0000);
        check("hlt_T2", idle(3'd2, 1'b0));
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("halted", idle(3'd0, 1'b1));
        end
        Reset = 1'b0;
        #1;
        check("halt_reset", idle(3'd0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
